// File: rtl/cacheline_burst_adapter_if.sv
// Interface for cacheline_burst_adapter: the L2 line-level handshake plus the 64-bit memory burst bus.
// The slave modport is the adapter's view; the master modport is the environment's view (L2 + memory).
interface cacheline_burst_adapter_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Splits 256-bit L2 line reads/writes into 4-beat 64-bit memory bursts and reassembles read beats.
// Optional macro CACHELINE_ADAPTER_ALIGN_EN forces address_o[4:0] to zero (line-aligned memory address).
module cacheline_burst_adapter #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input logic                     clk,
  input logic                     rst_n,
  cacheline_burst_adapter_if.slave bus
);
  localparam int s_beats = s_line / s_burst;
  localparam logic [1:0] last_beat = 2'(s_beats - 1);

  typedef enum logic [2:0] {IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE} state_t;

  state_t             state;
  logic [1:0]         count;
  logic [s_line-1:0]  rd_line;
  logic [s_line-1:0]  wr_line;
  logic [31:0]        addr;
  logic [s_burst-1:0] wr_beat;

  // Read and write lines are kept separately so line_o survives an intervening write burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= 2'd0;
      rd_line <= '0;
      wr_line <= '0;
      addr    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.read_i) begin
            addr  <= bus.address_i;
            count <= 2'd0;
            state <= RD_BURST;
          end else if (bus.write_i) begin
            addr    <= bus.address_i;
            wr_line <= bus.line_i;
            count   <= 2'd0;
            state   <= WR_BURST;
          end
        end
        RD_BURST: begin
          if (bus.resp_i) begin
            for (int k = 0; k < s_beats; k++) begin
              if (count == 2'(k)) rd_line[k*s_burst +: s_burst] <= bus.burst_i;
            end
            count <= count + 2'd1;
            if (count == last_beat) state <= RD_DONE;
          end
        end
        RD_DONE: state <= IDLE;
        WR_BURST: begin
          if (bus.resp_i) begin
            count <= count + 2'd1;
            if (count == last_beat) state <= WR_DONE;
          end
        end
        WR_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wr_beat = '0;
    for (int k = 0; k < s_beats; k++) begin
      if (count == 2'(k)) wr_beat = wr_line[k*s_burst +: s_burst];
    end
  end

  // Handshake outputs decode straight from the state register, so at most one is ever high.
  assign bus.read_o  = (state == RD_BURST);
  assign bus.write_o = (state == WR_BURST);
  assign bus.resp_o  = (state == RD_DONE) || (state == WR_DONE);
  assign bus.line_o  = rd_line;
  assign bus.burst_o = (state == WR_BURST) ? wr_beat : '0;

`ifdef CACHELINE_ADAPTER_ALIGN_EN
  assign bus.address_o = addr & ~32'h0000_001F;
`else
  assign bus.address_o = addr;
`endif

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed self-checking bench for cacheline_burst_adapter: reads, stalled reads, writes,
// simultaneous read/write requests and asynchronous reset in the middle of a burst.
module tb_cacheline_burst_adapter;
  logic clk = 1'b0;
  logic rst_n;
  int   compared    = 0;
  int   mismatched  = 0;
  int   resp_pulses = 0;

  always #5 clk = ~clk;

  cacheline_burst_adapter_if bus ();

  cacheline_burst_adapter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Pulses are counted away from the active edge so the count is race-free.
  always @(negedge clk) if (bus.resp_o === 1'b1) resp_pulses++;

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef CACHELINE_ADAPTER_ALIGN_EN
    return a & ~32'h0000_001F;
`else
    return a;
`endif
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic rd, input logic wr, input logic rsp);
    check({tag, ".read_o"},  {255'd0, bus.read_o},  {255'd0, rd});
    check({tag, ".write_o"}, {255'd0, bus.write_o}, {255'd0, wr});
    check({tag, ".resp_o"},  {255'd0, bus.resp_o},  {255'd0, rsp});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0]  beats_a [4];
    logic [63:0]  beats_b [4];
    logic [63:0]  beats_d [4];
    logic [63:0]  wr_exp  [4];
    logic [255:0] line_a, line_b, line_c, line_d;
    logic [6:0]   pat;
    int           nb;

    beats_a = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    beats_b = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    beats_d = '{64'hA0A0_0000_0000_0001, 64'hB1B1_0000_0000_0002,
                64'hC2C2_0000_0000_0003, 64'hD3D3_0000_0000_0004};
    wr_exp  = '{64'hA, 64'hB, 64'hC, 64'hD};
    line_a  = {beats_a[3], beats_a[2], beats_a[1], beats_a[0]};
    line_b  = {beats_b[3], beats_b[2], beats_b[1], beats_b[0]};
    line_c  = {64'hD, 64'hC, 64'hB, 64'hA};
    line_d  = {64'hFEED_0000_0000_0004, 64'hFEED_0000_0000_0003,
               64'hFEED_0000_0000_0002, 64'hFEED_0000_0000_0001};

    rst_n         = 1'b0;
    bus.line_i    = '0;
    bus.address_i = 32'd0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    #1;
    check_ctrl("reset", 1'b0, 1'b0, 1'b0);
    check("reset.line_o",    bus.line_o, 256'd0);
    check("reset.burst_o",   {192'd0, bus.burst_o}, 256'd0);
    check("reset.address_o", {224'd0, bus.address_o}, 256'd0);
    #12 rst_n = 1'b1;
    cycle();

    // Read with back-to-back beats.
    bus.address_i = 32'h0000_1040;
    bus.read_i    = 1'b1;
    cycle();
    check_ctrl("rd_a.c1", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = beats_a[k];
      cycle();
      check("rd_a.address_o", {224'd0, bus.address_o}, {224'd0, exp_addr(32'h0000_1040)});
      if (k < 3) check_ctrl("rd_a.beat", 1'b1, 1'b0, 1'b0);
      else       check_ctrl("rd_a.done", 1'b0, 1'b0, 1'b1);
    end
    check("rd_a.line_o", bus.line_o, line_a);
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    cycle();
    check_ctrl("rd_a.idle", 1'b0, 1'b0, 1'b0);
    check("rd_a.line_hold", bus.line_o, line_a);

    // Read with stalls: resp_i pattern 1,0,0,1,1,0,1.
    pat           = 7'b1011001;
    bus.address_i = 32'h0000_1040;
    bus.read_i    = 1'b1;
    cycle();
    check_ctrl("rd_b.c1", 1'b1, 1'b0, 1'b0);
    check("rd_b.line_before_beat", bus.line_o, line_a);
    bus.address_i = 32'hFFFF_FFFF;
    nb = 0;
    for (int i = 0; i < 7; i++) begin
      bus.resp_i  = pat[i];
      bus.burst_i = pat[i] ? beats_b[nb] : 64'hBAD0_BAD0_BAD0_BAD0;
      cycle();
      if (pat[i]) nb++;
      check("rd_b.address_o", {224'd0, bus.address_o}, {224'd0, exp_addr(32'h0000_1040)});
      if (nb < 4) check_ctrl("rd_b.step", 1'b1, 1'b0, 1'b0);
      else        check_ctrl("rd_b.done", 1'b0, 1'b0, 1'b1);
    end
    check("rd_b.line_o", bus.line_o, line_b);
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    cycle();
    check_ctrl("rd_b.idle", 1'b0, 1'b0, 1'b0);

    // Write burst; line_i is scrambled after acceptance and must be ignored.
    bus.line_i    = line_c;
    bus.address_i = 32'h0000_2000;
    bus.write_i   = 1'b1;
    cycle();
    check_ctrl("wr_c.c1", 1'b0, 1'b1, 1'b0);
    check("wr_c.burst0", {192'd0, bus.burst_o}, {192'd0, wr_exp[0]});
    check("wr_c.address_o", {224'd0, bus.address_o}, {224'd0, exp_addr(32'h0000_2000)});
    bus.line_i = '1;
    bus.resp_i = 1'b1;
    for (int k = 1; k < 4; k++) begin
      cycle();
      check_ctrl("wr_c.beat", 1'b0, 1'b1, 1'b0);
      check("wr_c.burst", {192'd0, bus.burst_o}, {192'd0, wr_exp[k]});
    end
    cycle();
    check_ctrl("wr_c.done", 1'b0, 1'b0, 1'b1);
    bus.resp_i  = 1'b0;
    bus.write_i = 1'b0;
    cycle();
    check_ctrl("wr_c.idle", 1'b0, 1'b0, 1'b0);

    // Simultaneous read and write: read first, write accepted after completion.
    resp_pulses   = 0;
    bus.line_i    = line_d;
    bus.address_i = 32'h0000_305C;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    cycle();
    check_ctrl("sim.rd_c1", 1'b1, 1'b0, 1'b0);
    check("sim.address_o", {224'd0, bus.address_o}, {224'd0, exp_addr(32'h0000_305C)});
    for (int k = 0; k < 4; k++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = beats_d[k];
      cycle();
      if (k < 3) check_ctrl("sim.rd_beat", 1'b1, 1'b0, 1'b0);
      else       check_ctrl("sim.rd_done", 1'b0, 1'b0, 1'b1);
    end
    check("sim.line_o", bus.line_o, {beats_d[3], beats_d[2], beats_d[1], beats_d[0]});
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    cycle();
    check_ctrl("sim.idle", 1'b0, 1'b0, 1'b0);
    cycle();
    check_ctrl("sim.wr_c1", 1'b0, 1'b1, 1'b0);
    check("sim.wr_burst0", {192'd0, bus.burst_o}, {192'd0, line_d[63:0]});
    bus.resp_i = 1'b1;
    cycle();
    check("sim.wr_burst1", {192'd0, bus.burst_o}, {192'd0, line_d[127:64]});
    cycle();
    check("sim.wr_burst2", {192'd0, bus.burst_o}, {192'd0, line_d[191:128]});
    cycle();
    check_ctrl("sim.wr_beat3", 1'b0, 1'b1, 1'b0);
    check("sim.wr_burst3", {192'd0, bus.burst_o}, {192'd0, line_d[255:192]});
    cycle();
    check_ctrl("sim.wr_done", 1'b0, 1'b0, 1'b1);
    bus.resp_i  = 1'b0;
    bus.write_i = 1'b0;
    cycle();
    check_ctrl("sim.idle2", 1'b0, 1'b0, 1'b0);
    check("sim.resp_pulses", {224'd0, 32'(resp_pulses)}, 256'd2);

    // Asynchronous reset after two beats of a read burst.
    bus.address_i = 32'h0000_4000;
    bus.read_i    = 1'b1;
    cycle();
    bus.resp_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.burst_i = beats_a[k];
      cycle();
      check_ctrl("rst.beat", 1'b1, 1'b0, 1'b0);
    end
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_ctrl("rst.async", 1'b0, 1'b0, 1'b0);
    check("rst.line_o", bus.line_o, 256'd0);
    check("rst.address_o", {224'd0, bus.address_o}, 256'd0);
    resp_pulses = 0;
    #3 rst_n = 1'b1;
    cycle();
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    cycle();
    check_ctrl("rst.idle1", 1'b0, 1'b0, 1'b0);
    bus.resp_i = 1'b0;
    cycle();
    check_ctrl("rst.idle2", 1'b0, 1'b0, 1'b0);
    check("rst.line_after", bus.line_o, 256'd0);
    check("rst.resp_pulses", {224'd0, 32'(resp_pulses)}, 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
